// File: rtl/result_serializer.sv
// Serializes 16-lane x 24-bit result words into one-pixel AXI4-Stream beats and issues
// pixel_ready credit to the feeder. Define RESULT_SERIALIZER_OVF_EN for the sticky overflow flag.
module result_serializer #(
  parameter int DEPTH          = 4,
  parameter int WORDS_PER_LINE = 8
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         pixel_valid,
  output logic         pixel_ready,
  input  logic [383:0] result,
  input  logic         result_valid,
  output logic [31:0]  m_axis_tdata,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic         m_axis_tlast,
  output logic         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [15:0]   LAST_WORD = 16'(WORDS_PER_LINE - 1);

  logic [383:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [3:0]    beat;
  logic [15:0]   line_cnt;
  logic          pv_d1;
  logic          pv_d2;
  logic          full;
  logic          fire;
  logic          pop;
  logic          wr_en;
  logic [CW:0]   reserved;
  logic [383:0]  head;
  logic [8:0]    lane_base;

  assign full          = (count == DEPTH_C);
  assign m_axis_tvalid = (count != '0);
  assign fire          = m_axis_tvalid && m_axis_tready;
  assign pop           = fire && (beat == 4'd15);
  // A pop on the same edge frees the slot the incoming word lands in.
  assign wr_en         = result_valid && (!full || pop);

  // Credit counts stored words plus results still travelling through the array.
  assign reserved    = {1'b0, count} + {{CW{1'b0}}, pv_d1} + {{CW{1'b0}}, pv_d2};
  assign pixel_ready = (reserved < {1'b0, DEPTH_C});

  assign head         = mem[rd_ptr];
  assign lane_base    = {2'b00, beat, 3'b000} + {1'b0, beat, 4'b0000};
  assign m_axis_tdata = m_axis_tvalid ? {8'h00, head[lane_base +: 24]} : 32'h0;
  assign m_axis_tlast = (beat == 4'd15) && (line_cnt == LAST_WORD);

  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem[wr_ptr] <= result;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      beat     <= '0;
      line_cnt <= '0;
      pv_d1    <= 1'b0;
      pv_d2    <= 1'b0;
    end else begin
      pv_d1 <= pixel_valid;
      pv_d2 <= pv_d1;
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (fire) begin
        beat <= beat + 4'd1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        line_cnt <= (line_cnt == LAST_WORD) ? 16'd0 : line_cnt + 16'd1;
      end
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef RESULT_SERIALIZER_OVF_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      overflow <= 1'b0;
    end else if (result_valid && full && !pop) begin
      overflow <= 1'b1;
    end
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_result_serializer.sv
// Randomized self-checking bench for result_serializer against a queue-based reference model.
module tb_result_serializer;

  localparam int DEPTH = 4;
  localparam int WPL   = 3;
`ifdef RESULT_SERIALIZER_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         aclk = 1'b0;
  logic         aresetn = 1'b1;
  logic         pixel_valid = 1'b0;
  logic         pixel_ready;
  logic [383:0] result = '0;
  logic         result_valid = 1'b0;
  logic [31:0]  m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b0;
  logic         m_axis_tlast;
  logic         overflow;

  int checks = 0;
  int errors = 0;
  int feedCount = 0;
  int beatCount = 0;

  logic [383:0] refQ[$];
  int   refBeat = 0;
  int   refLine = 0;
  logic refOvf  = 1'b0;
  logic refPv1  = 1'b0;
  logic refPv2  = 1'b0;
  logic feedD1  = 1'b0;
  logic feedD2  = 1'b0;

  always #5 aclk = ~aclk;

  result_serializer #(.DEPTH(DEPTH), .WORDS_PER_LINE(WPL)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .pixel_valid   (pixel_valid),
    .pixel_ready   (pixel_ready),
    .result        (result),
    .result_valid  (result_valid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .overflow      (overflow)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [383:0] randWord();
    logic [383:0] w;
    for (int i = 0; i < 12; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Expected outputs follow directly from the model's word queue and beat/line position.
  task automatic compareOutputs();
    logic         expValid;
    logic [383:0] w;
    int           reserved;
    expValid = (refQ.size() != 0);
    reserved = refQ.size() + int'(refPv1) + int'(refPv2);
    checkOutput("tvalid", 32'(m_axis_tvalid), 32'(expValid));
    if (expValid) begin
      w = refQ[0];
      checkOutput("tdata", m_axis_tdata, {8'h00, w[refBeat*24 +: 24]});
    end
    checkOutput("tlast", 32'(m_axis_tlast), 32'(expValid && refBeat == 15 && refLine == WPL - 1));
    checkOutput("pixel_ready", 32'(pixel_ready), 32'(reserved < DEPTH));
    checkOutput("overflow", 32'(overflow), 32'(OVF_EN && refOvf));
  endtask

  task automatic modelStep(input logic pv, input logic rv, input logic [383:0] data, input logic rdy);
    logic hasHead;
    logic popNow;
    logic isFull;
    hasHead = (refQ.size() != 0);
    isFull  = (refQ.size() == DEPTH);
    popNow  = hasHead && rdy && refBeat == 15;
    if (hasHead && rdy) refBeat = (refBeat + 1) % 16;
    if (popNow) begin
      void'(refQ.pop_front());
      refLine = (refLine == WPL - 1) ? 0 : refLine + 1;
    end
    if (rv && (!isFull || popNow)) refQ.push_back(data);
    else if (rv) refOvf = 1'b1;
    refPv2 = refPv1;
    refPv1 = pv;
  endtask

  // One clock cycle: drive, compare at the falling edge, advance the model, return after posedge.
  task automatic applyStimulus(input logic pv, input logic rv, input logic [383:0] data, input logic rdy);
    pixel_valid   = pv;
    result_valid  = rv;
    result        = data;
    m_axis_tready = rdy;
    @(negedge aclk);
    compareOutputs();
    if (m_axis_tvalid && rdy) beatCount++;
    modelStep(pv, rv, data, rdy);
    @(posedge aclk);
    #1;
  endtask

  // Well-behaved feeder: pixel_valid only under credit, result two cycles later.
  task automatic feederCycle(input logic want, input logic rdy, input logic rogue);
    logic pv;
    logic rv;
    pv = want && pixel_ready;
    rv = feedD2 || rogue;
    if (pv) feedCount++;
    applyStimulus(pv, rv, randWord(), rdy);
    feedD2 = feedD1;
    feedD1 = pv;
  endtask

  task automatic doReset();
    pixel_valid   = 1'b0;
    result_valid  = 1'b0;
    m_axis_tready = 1'b0;
    aresetn       = 1'b0;
    #1;
    checkOutput("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    checkOutput("rst_tlast", 32'(m_axis_tlast), 32'd0);
    checkOutput("rst_tdata", m_axis_tdata, 32'd0);
    checkOutput("rst_pixel_ready", 32'(pixel_ready), 32'd1);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    refQ.delete();
    refBeat = 0;
    refLine = 0;
    refOvf  = 1'b0;
    refPv1  = 1'b0;
    refPv2  = 1'b0;
    feedD1  = 1'b0;
    feedD2  = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  initial begin
    logic [383:0] w;
    #2;
    doReset();

    // Single word with recognisable lanes, drained with tready held high.
    for (int k = 0; k < 16; k++) w[k*24 +: 24] = 24'(k * 65536 + k);
    applyStimulus(1'b0, 1'b1, w, 1'b1);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1);

    // Credit: stalled output, feeder follows pixel_ready.
    feedCount = 0;
    for (int i = 0; i < 12; i++) feederCycle(1'b1, 1'b0, 1'b0);
    checkOutput("credit_pulses", 32'(feedCount), 32'd4);
    checkOutput("credit_ready", 32'(pixel_ready), 32'd0);
    checkOutput("credit_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 70; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1);

    // Backpressure over three words.
    feedCount = 0;
    beatCount = 0;
    for (int i = 0; i < 200; i++) feederCycle(feedCount < 3, 1'($urandom % 2), 1'b0);
    for (int i = 0; i < 100 && refQ.size() != 0; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("bp_beats", 32'(beatCount), 32'd48);
    checkOutput("bp_drained", 32'(m_axis_tvalid), 32'd0);

    // Full FIFO, write lands on the beat-15 pop.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, randWord(), 1'b0);
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b1, randWord(), 1'b1);
    checkOutput("simul_overflow", 32'(overflow), 32'd0);
    checkOutput("simul_ready", 32'(pixel_ready), 32'd0);
    for (int i = 0; i < 70; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1);

    // Forced write into a full, stalled FIFO.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, randWord(), 1'b0);
    applyStimulus(1'b0, 1'b1, randWord(), 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("ovf_set", 32'(overflow), 32'(OVF_EN));
    for (int i = 0; i < 70; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("ovf_sticky", 32'(overflow), 32'(OVF_EN));

    // Random traffic with occasional rogue results, then reset in the middle of it.
    for (int i = 0; i < 300; i++)
      feederCycle(1'($urandom % 2), 1'($urandom % 4 != 0), 1'($urandom % 32 == 0));
    for (int i = 0; i < 7; i++) feederCycle(1'b1, 1'b1, 1'b0);
    doReset();
    for (int i = 0; i < 100; i++) feederCycle(1'($urandom % 2), 1'($urandom % 3 != 0), 1'b0);
    for (int i = 0; i < 100; i++) applyStimulus(1'b0, feedD2, randWord(), 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/result_serializer.md
# result_serializer

Downstream stage of the systolic interpolation array. Captures each 16-lane × 24-bit RGB result word on `result_valid` into a small word FIFO, then emits it one pixel per beat on a 32-bit AXI4-Stream master with full backpressure. The array has no stall input, so this block also generates a credit signal, `pixel_ready`, which the pixel feeder uses to gate `pixel_valid`. This guarantees that no result is ever dropped.

## Interface
Parameters:
- `DEPTH`, 4: FIFO depth in 384-bit words. Must be a power of 2 and at least 4.
- `WORDS_PER_LINE`, 8: number of result words per output line. Controls `tlast` placement. Range 1–65535.

Ports:
- `aclk` in 1: clock.
- `aresetn` in 1: asynchronous active-low reset.
- `pixel_valid` in 1: copy of the strobe driven into the systolic array. Used only for in-flight tracking.
- `pixel_ready` out 1: the feeder may assert `pixel_valid` this cycle.
- `result` in 384: 16 lanes. Lane k is `result[24k+23:24k]`, ordered {R,G,B}.
- `result_valid` in 1: `result` is valid this cycle.
- `m_axis_tdata` out 32: {8'h00, lane}.
- `m_axis_tvalid` out 1.
- `m_axis_tready` in 1.
- `m_axis_tlast` out 1.
- `overflow` out 1: sticky error flag (see Configuration).

## Operation
- **In-flight tracking.**
  - `pv_d1` and `pv_d2` are `pixel_valid` delayed by 1 and 2 cycles.
  - `pixel_ready` = (`count` + `pv_d1` + `pv_d2`) < `DEPTH`. This is combinational from registers.
  - Pops in the current cycle are ignored, which makes the check conservative.
- **Write.**
  - When `result_valid` is high and `count` < `DEPTH`: write `result` at `wr_ptr` and increment `wr_ptr`.
  - Pointers wrap modulo `DEPTH`.
- **Read.**
  - `m_axis_tvalid` = (`count` ≠ 0).
  - `beat` is a 4-bit counter that selects the lane of the head word. Lane 0 is emitted first.
  - A beat transfers when `tvalid` and `tready` are both high; `beat` then increments.
  - On the transfer where `beat` = 15: the head word is popped, `rd_ptr` increments and `beat` wraps to 0.
- **Count.**
  - +1 on a write, −1 on a pop.
  - A simultaneous write and pop leaves `count` unchanged. This includes the case `count` = `DEPTH`, where the pop frees the slot in the same cycle the write uses it.
- **Line framing.**
  - `line_cnt` counts popped words.
  - `m_axis_tlast` = (`beat` = 15) && (`line_cnt` = `WORDS_PER_LINE`−1).
  - `line_cnt` wraps to 0 on the pop that carries `tlast`.
- **AXIS stability.** While `tvalid` is high and `tready` is low, `tdata` and `tlast` hold constant. They are driven from FIFO storage, which is never overwritten while occupied.
- **Lost results.** If `result_valid` arrives while `count` = `DEPTH` and no pop occurs that cycle, the word is discarded and the FIFO is unchanged. This can only happen if the feeder ignored `pixel_ready`.

## Timing
- **Reset values.** `count`, `wr_ptr`, `rd_ptr`, `beat`, `line_cnt`, `pv_d1`, `pv_d2` and `overflow` are all 0. As a result `m_axis_tvalid` = 0, `m_axis_tlast` = 0, `m_axis_tdata` = 0, and `pixel_ready` = 1.
- **Storage array.** Not reset. `tdata` is a don't-care while `tvalid` = 0.
- **Result to output latency.** `result_valid` in cycle t gives `m_axis_tvalid` in cycle t+1, when the FIFO was empty.
- **Throughput.** With `tready` held at 1, each word drains in 16 cycles. The sustained input rate is therefore 1 word per 16 cycles.
- **Credit window.** `pixel_valid` in cycle t maps to `result_valid` in cycle t+2. The `pv_d1`/`pv_d2` term reserves a slot for each in-flight result.
- **Reset mid-operation.** Asserting `aresetn` low immediately clears all state, drops all stored words and drops all in-flight credit. There is no partial beat afterwards; the next beat is lane 0.

## Configuration
- `RESULT_SERIALIZER_OVF_EN` defined:
  - `overflow` is set to 1 on any discarded `result_valid` (FIFO full and no pop that cycle).
  - It stays set until reset.
- Not defined:
  - The overflow logic is not compiled and `overflow` is tied to 0.
  - The discard behaviour is identical.

## Test plan
- **Reset.**
  - Stimulus: reset, then release `aresetn`.
  - Required: `pixel_ready` = 1, `m_axis_tvalid` = 0, `overflow` = 0.
- **Single word.**
  - Stimulus: one `result_valid` where lane k = 24'h010000·k + k, with `tready` = 1.
  - Required: 16 beats, beat k `tdata` = {8'h00, lane k}. `tvalid` rises 1 cycle after `result_valid`. `tlast` only on beat 15 when `WORDS_PER_LINE` = 1.
- **Credit.**
  - Stimulus: `DEPTH` = 4, `tready` = 0, drive `pixel_valid` every cycle that `pixel_ready` = 1, and generate `result_valid` 2 cycles after each.
  - Required: exactly 4 words accepted, `pixel_ready` low once `count` + in-flight = 4, `overflow` = 0.
- **Backpressure.**
  - Stimulus: toggle `tready` at random over 3 words.
  - Required: `tdata` and `tlast` stable while stalled, 48 beats in lane order, no beat duplicated or skipped.
- **Simultaneous write and pop.**
  - Stimulus: FIFO full; `result_valid` in the same cycle as the beat-15 handshake.
  - Required: `count` stays 4, new word accepted, `overflow` = 0.
- **Overflow (macro defined).**
  - Stimulus: FIFO full, `tready` = 0, force `result_valid`.
  - Required: `overflow` = 1 next cycle and remains set; the stored words drain unchanged.
